// File: rtl/exe_muldiv_unit.sv
// RV32M/RV64M multiply/divide execute unit.
// Fixed-latency multiply, restoring radix-2 divide with a sign-fix cycle.
module exe_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 2,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2:0]          op_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    input  logic [REG_BITS-1:0] rd_addr_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     result_o,
    output logic [REG_BITS-1:0] rd_addr_o,
    output logic                busy_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] C_MUL_END =
        CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CW-1:0] C_DIV_END = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_op;
    logic [REG_BITS-1:0]   r_rd;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_result;
    logic [CW-1:0]         r_cnt;
    logic                  r_neg_q;
    logic                  r_neg_r;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic                  w_div_fast;
    logic [XLEN-1:0]       w_fast_res;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;

    logic [2:0]            w_mop;
    logic [XLEN-1:0]       w_ma;
    logic [XLEN-1:0]       w_mb;
    logic                  w_sa;
    logic                  w_sb;
    logic [2*XLEN-1:0]     w_ma_ext;
    logic [2*XLEN-1:0]     w_mb_ext;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_mul_res;

    logic [XLEN:0]         w_rem_sh;
    logic [XLEN:0]         w_diff;
    logic [XLEN-1:0]       w_q_fix;
    logic [XLEN-1:0]       w_r_fix;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_idle & in_valid_i & ~flush_i;
    assign in_ready_o  = w_idle;
    assign out_valid_o = (r_state == S_DONE);
    assign busy_o      = ~w_idle;
    assign result_o    = r_result;
    assign rd_addr_o   = r_rd;

    assign w_div_zero = (rs2_i == '0);
    assign w_div_ovf  = ~op_i[0] & (rs1_i == C_MIN) & (rs2_i == '1);
    assign w_div_fast = w_div_zero | w_div_ovf;
    assign w_fast_res = w_div_zero ? (op_i[1] ? rs1_i : '1)
                                   : (op_i[1] ? '0 : rs1_i);

    assign w_a_neg = ~op_i[0] & rs1_i[XLEN-1];
    assign w_b_neg = ~op_i[0] & rs2_i[XLEN-1];
    assign w_mag_a = w_a_neg ? -rs1_i : rs1_i;
    assign w_mag_b = w_b_neg ? -rs2_i : rs2_i;

    // Shared multiplier: fed from the ports at accept (for MUL_LAT=1),
    // from the captured operands while counting.
    assign w_mop    = w_idle ? op_i : r_op;
    assign w_ma     = w_idle ? rs1_i : r_a;
    assign w_mb     = w_idle ? rs2_i : r_b;
    assign w_sa     = (w_mop[1:0] != 2'b11);
    assign w_sb     = (w_mop[1:0] == 2'b01);
    assign w_ma_ext = {{XLEN{w_sa & w_ma[XLEN-1]}}, w_ma};
    assign w_mb_ext = {{XLEN{w_sb & w_mb[XLEN-1]}}, w_mb};
    assign w_prod   = w_ma_ext * w_mb_ext;
    assign w_mul_res = (w_mop[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                             : w_prod[2*XLEN-1:XLEN];

    assign w_rem_sh = {r_rem, r_a[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_q_fix  = r_neg_q ? -r_a : r_a;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (!op_i[2]) begin
                            w_next = (MUL_LAT == 1) ? S_DONE : S_MUL;
                        end else if (w_div_fast) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_DIV;
                        end
                    end
                end
                S_MUL: if (r_cnt == C_MUL_END) w_next = S_DONE;
                S_DIV: if (r_cnt == C_DIV_END) w_next = S_FIX;
                S_FIX: w_next = S_DONE;
                S_DONE: if (out_ready_i) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_i;
                        r_rd    <= rd_addr_i;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        // Divides keep magnitudes; r_a becomes the quotient.
                        r_a <= op_i[2] ? w_mag_a : rs1_i;
                        r_b <= op_i[2] ? w_mag_b : rs2_i;
                        if (!op_i[2]) begin
                            r_result <= w_mul_res;
                        end else if (w_div_fast) begin
                            r_result <= w_fast_res;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_result <= w_mul_res;
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_diff[XLEN]) begin
                        r_rem <= w_diff[XLEN-1:0];
                        r_a   <= {r_a[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[XLEN-1:0];
                        r_a   <= {r_a[XLEN-2:0], 1'b0};
                    end
                end
                S_FIX: r_result <= r_op[1] ? w_r_fix : w_q_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/exe_muldiv_unit.md
EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values are 32 and 64.
REQ-002 Parameter MUL_LAT, default 2: multiply latency in cycles; legal range is 1..4.
REQ-003 Parameter REG_BITS, default 5: width of the destination-register tag.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 flush_i  input  1  abort the in-flight operation (branch or trap).
REQ-007 in_valid_i  input  1  a request is present on op_i, rs1_i, rs2_i and rd_addr_i.
REQ-008 in_ready_o  output  1  the unit accepts a request this cycle.
REQ-009 op_i  input  3  RV M-extension func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 rs1_i, rs2_i  input  XLEN each  operands, already forwarded.
REQ-011 rd_addr_i  input  REG_BITS  destination tag.
REQ-012 out_valid_o  output  1  result_o and rd_addr_o are valid.
REQ-013 out_ready_i  input  1  the consumer (EX/MEM register) takes the result this cycle.
REQ-014 result_o  output  XLEN  operation result.
REQ-015 rd_addr_o  output  REG_BITS  tag of the operation being returned.
REQ-016 busy_o  output  1  an operation is accepted but not yet retired; used by the hazard unit to stall IF/ID/EX.

Function
REQ-017 The unit SHALL be a state machine with states IDLE, MUL, DIV, FIX and DONE.
REQ-018 in_ready_o SHALL be 1 only in IDLE; a request is accepted on a rising edge where in_valid_i=1, in_ready_o=1 and flush_i=0.
REQ-019 Operands, op and tag SHALL be captured at acceptance; later input changes SHALL have no effect on that operation.
REQ-020 Accepted MUL* ops SHALL enter MUL, count MUL_LAT-1 cycles, then enter DONE, so out_valid_o rises MUL_LAT cycles after the accept edge.
REQ-021 MUL SHALL return product bits [XLEN-1:0].
REQ-022 MULH, MULHSU and MULHU SHALL return bits [2*XLEN-1:XLEN] of the signed×signed, signed×unsigned and unsigned×unsigned 2*XLEN-bit product respectively.
REQ-023 Division by zero SHALL return quotient all-ones and remainder = rs1 (both signed and unsigned).
REQ-024 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1) SHALL return quotient = rs1 and remainder = 0.
REQ-025 Division by zero and signed overflow SHALL go directly to DONE (out_valid_o one cycle after accept).
REQ-026 Other divides SHALL enter DIV, run XLEN restoring radix-2 iterations on operand magnitudes (one bit per cycle), then spend one FIX cycle negating: quotient when the operand signs differ, remainder when rs1 was negative (signed ops only); out_valid_o rises XLEN+2 cycles after accept.
REQ-027 In DONE, out_valid_o=1 and result_o/rd_addr_o SHALL hold stable until a cycle with out_ready_i=1; the unit then returns to IDLE on that edge.
REQ-028 busy_o SHALL be 1 in MUL, DIV, FIX and DONE, and 0 in IDLE.
REQ-029 flush_i=1 in any state SHALL force IDLE on the next edge with out_valid_o=0; no result from the flushed op is ever presented.
REQ-030 flush_i has priority over acceptance and over out_ready_i.
REQ-031 All arithmetic SHALL be exact to XLEN with no truncation before the final selection; remainder sign follows the dividend.

Reset
REQ-032 While rst=0 at a rising edge, the state SHALL become IDLE, counters 0 and result_o/rd_addr_o 0.
REQ-033 During and after reset, out_valid_o=0 and busy_o=0; in_ready_o=1 from the first edge with rst=1.
REQ-034 Reset mid-operation SHALL discard the operation; no result is presented.

Verification
REQ-035 XLEN=32, MUL_LAT=2: MUL and MULH of 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001 and 0x00000000; MULHU -> 0xFFFFFFFE; out_valid 2 cycles after accept.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each valid 1 cycle after accept; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7.
REQ-037 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, valid 34 cycles after accept, busy_o high for the whole interval.
REQ-038 DIVU 100/7 with out_ready_i held 0 for 5 cycles after out_valid -> result 14 held stable, in_ready_o=0 throughout, IDLE one cycle after out_ready_i=1.
REQ-039 flush_i pulse 10 cycles into a divide -> in_ready_o=1 next cycle, out_valid_o never asserts; a new MUL 3×5 then returns 15.
REQ-040 rst=0 during the DIV state -> out_valid_o=0 and busy_o=0 after the edge; the next request completes normally.
